sprite_config_rx: RTL and testbench

- Serial configuration receiver directly upstream of the sprite movement stage.
- Synchronises a 3-wire SPI-style host link (sclk, sdi, cs_n) into the system clock domain.
- Decodes a command byte, then forwards payload bits as single-cycle shift strobes plus data bits to the selected target:
  - sprite X position
  - sprite Y position
  - sprite bitmap
  - sprite colour
- Enforces per-target payload lengths and reports frame completion and errors.

---
 rtl/sprite_config_rx.sv | 157 +++++++++++++++
 tb/tb_sprite_config_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_config_rx.sv
// SPI-style configuration receiver: synchronises sclk/sdi/cs_n, decodes a command
// byte and forwards payload bits as one-cycle shift strobes to the selected sprite target.
module sprite_config_rx #(
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 8,
  parameter int SPRITE_BITS = 64,
  parameter int COLOR_BITS  = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic sdi,
  input  logic cs_n,
  output logic shift_x,
  output logic data_in_x,
  output logic shift_y,
  output logic data_in_y,
  output logic shift_sprite,
  output logic data_in_sprite,
  output logic shift_color,
  output logic data_in_color,
  output logic frame_done,
  output logic frame_error,
  output logic busy
);

  localparam int MAX_XY  = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;
  localparam int MAX_SC  = (SPRITE_BITS > COLOR_BITS) ? SPRITE_BITS : COLOR_BITS;
  localparam int MAX_LEN = (MAX_XY > MAX_SC) ? MAX_XY : MAX_SC;
  localparam int CW_RAW  = $clog2(MAX_LEN) + 1;
  // The same counter also counts the 8 command bits, so it needs at least 4 bits.
  localparam int CW      = (CW_RAW < 4) ? 4 : CW_RAW;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
    IGNORE = 3'd4
  } state_t;

  state_t          state;
  logic            sclk_s1, sclk_s2, sclk_s3;
  logic            sdi_s1, sdi_s2;
  logic            cs_s1, cs_s2;
  logic [6:0]      cmd_sr;
  logic [1:0]      target;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   tgt_len;
  logic            rise;

  assign rise = sclk_s2 & ~sclk_s3;

  always_comb begin
    tgt_len = CW'(X_BITS);
    case (target)
      2'd0:    tgt_len = CW'(X_BITS);
      2'd1:    tgt_len = CW'(Y_BITS);
      2'd2:    tgt_len = CW'(SPRITE_BITS);
      default: tgt_len = CW'(COLOR_BITS);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      sclk_s1        <= 1'b0;
      sclk_s2        <= 1'b0;
      sclk_s3        <= 1'b0;
      sdi_s1         <= 1'b0;
      sdi_s2         <= 1'b0;
      cs_s1          <= 1'b1;
      cs_s2          <= 1'b1;
      cmd_sr         <= '0;
      target         <= '0;
      cnt            <= '0;
      shift_x        <= 1'b0;
      data_in_x      <= 1'b0;
      shift_y        <= 1'b0;
      data_in_y      <= 1'b0;
      shift_sprite   <= 1'b0;
      data_in_sprite <= 1'b0;
      shift_color    <= 1'b0;
      data_in_color  <= 1'b0;
      frame_done     <= 1'b0;
      frame_error    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      sdi_s1  <= sdi;
      sdi_s2  <= sdi_s1;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      busy    <= ~cs_s2;

      shift_x      <= 1'b0;
      shift_y      <= 1'b0;
      shift_sprite <= 1'b0;
      shift_color  <= 1'b0;
      frame_done   <= 1'b0;
      frame_error  <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!cs_s2) state <= CMD;
        end
        CMD: begin
          if (cs_s2) begin
            state       <= IDLE;
            frame_error <= 1'b1;
          end else if (rise) begin
            cmd_sr <= {cmd_sr[5:0], sdi_s2};
            // On the 8th bit the full command is {cmd_sr, sdi_s2}; bits [3:2] are reserved.
            if (cnt == CW'(7)) begin
              cnt <= '0;
              if (cmd_sr[6:3] == 4'hA) begin
                state  <= DATA;
                target <= {cmd_sr[0], sdi_s2};
              end else begin
                state       <= IGNORE;
                frame_error <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (cs_s2) begin
            state <= IDLE;
            if (cnt == tgt_len) frame_done <= 1'b1;
            else if (cnt != '0) frame_error <= 1'b1;
          end else if (cnt == tgt_len) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else if (rise) begin
            cnt <= cnt + 1'b1;
            case (target)
              2'd0: begin shift_x      <= 1'b1; data_in_x      <= sdi_s2; end
              2'd1: begin shift_y      <= 1'b1; data_in_y      <= sdi_s2; end
              2'd2: begin shift_sprite <= 1'b1; data_in_sprite <= sdi_s2; end
              default: begin shift_color <= 1'b1; data_in_color <= sdi_s2; end
            endcase
          end
        end
        DONE, IGNORE: begin
          if (cs_s2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_config_rx.sv
// Directed bench for sprite_config_rx: host-side sclk/sdi/cs_n driver, expected strobe
// queue checked by a strobe monitor, pulse counters and a final report.
module tb_sprite_config_rx;

  logic clk = 1'b0;
  logic reset, sclk, sdi, cs_n;
  logic shift_x, data_in_x, shift_y, data_in_y;
  logic shift_sprite, data_in_sprite, shift_color, data_in_color;
  logic frame_done, frame_error, busy;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err = 0;
  int n_strobe = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;
  bit last_valid = 0;
  bit prev_any = 0;
  logic [2:0] exp_q[$];

  sprite_config_rx dut (
    .clk(clk), .reset(reset), .sclk(sclk), .sdi(sdi), .cs_n(cs_n),
    .shift_x(shift_x), .data_in_x(data_in_x),
    .shift_y(shift_y), .data_in_y(data_in_y),
    .shift_sprite(shift_sprite), .data_in_sprite(data_in_sprite),
    .shift_color(shift_color), .data_in_color(data_in_color),
    .frame_done(frame_done), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    logic any;
    logic [2:0] obs;
    cyc++;
    if (reset) begin
      prev_any   = 0;
      last_valid = 0;
    end else begin
      any = shift_x | shift_y | shift_sprite | shift_color;
      if (frame_done) n_done++;
      if (frame_error) n_err++;
      if (frame_done || frame_error) check("pulse_exclusive", {31'd0, frame_done & frame_error}, 0);
      if (any) begin
        n_strobe++;
        check("strobe_width", {31'd0, prev_any}, 0);
        check("strobe_onehot", $countones({shift_x, shift_y, shift_sprite, shift_color}), 1);
        if (shift_x)           obs = {2'd0, data_in_x};
        else if (shift_y)      obs = {2'd1, data_in_y};
        else if (shift_sprite) obs = {2'd2, data_in_sprite};
        else                   obs = {2'd3, data_in_color};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_strobe: observed %0h expected none", obs);
        end else begin
          check("strobe_data", {29'd0, obs}, {29'd0, exp_q.pop_front()});
        end
        if (last_valid) check("strobe_spacing_ge6", {31'd0, (cyc - last_strobe_cyc) >= 6}, 1);
        last_strobe_cyc = cyc;
        last_valid      = 1;
      end
      prev_any = any;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_bit(input logic b, input int ph);
    sdi = b;
    wait_clk(ph);
    sclk = 1'b1;
    wait_clk(ph);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int ph, input bit fwd, input logic [1:0] tgt);
    for (int i = 7; i >= 0; i--) begin
      if (fwd) exp_q.push_back({tgt, v[i]});
      sclk_bit(v[i], ph);
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_clk(5);
    check("busy_high", {31'd0, busy}, 1);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    wait_clk(5);
    check("busy_low", {31'd0, busy}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, s0;
    reset = 1'b1; sclk = 1'b0; sdi = 1'b0; cs_n = 1'b1;
    wait_clk(3);
    check("reset_outputs", {21'd0, shift_x, data_in_x, shift_y, data_in_y, shift_sprite,
                            data_in_sprite, shift_color, data_in_color, frame_done,
                            frame_error, busy}, 0);
    reset = 1'b0;
    wait_clk(4);

    // 1: X write 0x5C
    d0 = n_done; e0 = n_err; s0 = n_strobe;
    cs_low();
    send_byte(8'hA0, 4, 0, 2'd0);
    send_byte(8'h5C, 4, 1, 2'd0);
    wait_clk(8);
    cs_high();
    check("t1_done", n_done - d0, 1);
    check("t1_err", n_err - e0, 0);
    check("t1_strobes", n_strobe - s0, 8);
    check("t1_queue", exp_q.size(), 0);

    // 2: bitmap write, alternating bits, then extra rises
    d0 = n_done; e0 = n_err; s0 = n_strobe;
    cs_low();
    send_byte(8'hA2, 4, 0, 2'd0);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({2'd2, (i % 2 == 0) ? 1'b1 : 1'b0});
      sclk_bit((i % 2 == 0) ? 1'b1 : 1'b0, 4);
    end
    wait_clk(8);
    check("t2_done", n_done - d0, 1);
    for (int i = 0; i < 4; i++) sclk_bit(1'b1, 4);
    wait_clk(8);
    cs_high();
    check("t2_strobes", n_strobe - s0, 64);
    check("t2_done_once", n_done - d0, 1);
    check("t2_err", n_err - e0, 0);
    check("t2_queue", exp_q.size(), 0);

    // 3: bad command 0x31 followed by 8 bits
    d0 = n_done; e0 = n_err; s0 = n_strobe;
    cs_low();
    send_byte(8'h31, 4, 0, 2'd0);
    wait_clk(6);
    check("t3_err_after_cmd", n_err - e0, 1);
    send_byte(8'hA5, 4, 0, 2'd0);
    wait_clk(6);
    check("t3_busy_held", {31'd0, busy}, 1);
    cs_high();
    check("t3_err", n_err - e0, 1);
    check("t3_done", n_done - d0, 0);
    check("t3_strobes", n_strobe - s0, 0);

    // 4: truncated colour frame, then a normal Y frame
    d0 = n_done; e0 = n_err; s0 = n_strobe;
    cs_low();
    send_byte(8'hA3, 4, 0, 2'd0);
    exp_q.push_back({2'd3, 1'b1}); sclk_bit(1'b1, 4);
    exp_q.push_back({2'd3, 1'b0}); sclk_bit(1'b0, 4);
    exp_q.push_back({2'd3, 1'b1}); sclk_bit(1'b1, 4);
    wait_clk(6);
    cs_high();
    check("t4_trunc_err", n_err - e0, 1);
    check("t4_trunc_strobes", n_strobe - s0, 3);
    check("t4_trunc_done", n_done - d0, 0);
    cs_low();
    send_byte(8'hA1, 4, 0, 2'd0);
    send_byte(8'h96, 4, 1, 2'd1);
    wait_clk(8);
    cs_high();
    check("t4_next_done", n_done - d0, 1);
    check("t4_next_err", n_err - e0, 1);
    check("t4_queue", exp_q.size(), 0);

    // 5: reset in the middle of a Y payload
    d0 = n_done; e0 = n_err; s0 = n_strobe;
    cs_low();
    send_byte(8'hA1, 4, 0, 2'd0);
    exp_q.push_back({2'd1, 1'b1}); sclk_bit(1'b1, 4);
    exp_q.push_back({2'd1, 1'b0}); sclk_bit(1'b0, 4);
    exp_q.push_back({2'd1, 1'b1}); sclk_bit(1'b1, 4);
    exp_q.push_back({2'd1, 1'b1}); sclk_bit(1'b1, 4);
    wait_clk(6);
    reset = 1'b1;
    cs_n = 1'b1;
    #1;
    check("t5_reset_outputs", {21'd0, shift_x, data_in_x, shift_y, data_in_y, shift_sprite,
                               data_in_sprite, shift_color, data_in_color, frame_done,
                               frame_error, busy}, 0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(5);
    check("t5_no_pulses", (n_done - d0) + (n_err - e0), 0);
    check("t5_partial_strobes", n_strobe - s0, 4);
    cs_low();
    send_byte(8'hA1, 4, 0, 2'd0);
    send_byte(8'hFF, 4, 1, 2'd1);
    wait_clk(8);
    cs_high();
    check("t5_done", n_done - d0, 1);
    check("t5_strobes", n_strobe - s0, 12);
    check("t5_queue", exp_q.size(), 0);

    // 6: minimum 3-cycle sclk phases, X then Y back to back
    d0 = n_done; e0 = n_err; s0 = n_strobe;
    cs_low();
    send_byte(8'hA0, 3, 0, 2'd0);
    send_byte(8'h3C, 3, 1, 2'd0);
    wait_clk(6);
    cs_high();
    cs_low();
    send_byte(8'hA1, 3, 0, 2'd0);
    send_byte(8'hC3, 3, 1, 2'd1);
    wait_clk(6);
    cs_high();
    check("t6_done", n_done - d0, 2);
    check("t6_err", n_err - e0, 0);
    check("t6_strobes", n_strobe - s0, 16);
    check("t6_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
